// File: rtl/onchip_memory_rr_arbiter.sv
// Two-master round-robin arbiter with a bounded hold window in front of a single-port on-chip RAM.
// Optional per-master grant counters are enabled with ARB_PERF_CNT_EN.
module onchip_memory_rr_arbiter #(
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned BE_W     = 4,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
`ifdef ARB_PERF_CNT_EN
    ,
    input  logic              cnt_clear,
    output logic [31:0]       m0_grant_count,
    output logic [31:0]       m1_grant_count
`endif
);

    localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

    state_t     state;
    logic       last_grant;
    logic [3:0] hold_cnt;
    logic [1:0] rd_pend;
    logic [1:0] grant;
    logic       req0, req1;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // The current owner keeps a contested grant only while its window is open;
    // from IDLE the master other than last_grant wins the tie.
    always_comb begin
        grant = '0;
        if (reset_n) begin
            if (req0 && !req1) begin
                grant = 2'b01;
            end else if (req1 && !req0) begin
                grant = 2'b10;
            end else if (req0 && req1) begin
                if (state != IDLE && hold_cnt < HOLD_MAX)
                    grant = last_grant ? 2'b10 : 2'b01;
                else
                    grant = last_grant ? 2'b01 : 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_grant <= 1'b0;
            hold_cnt   <= '0;
            rd_pend    <= '0;
        end else begin
            rd_pend <= {grant[1] & m1_read & ~m1_write, grant[0] & m0_read & ~m0_write};
            if (grant == 2'b00) begin
                state    <= IDLE;
                hold_cnt <= '0;
            end else begin
                if (grant[1] == last_grant) begin
                    if (hold_cnt < HOLD_MAX)
                        hold_cnt <= hold_cnt + 4'd1;
                end else begin
                    hold_cnt <= 4'd1;
                end
                last_grant <= grant[1];
                state      <= grant[1] ? OWN1 : OWN0;
            end
        end
    end

    assign m0_waitrequest   = ~reset_n | (req0 & ~grant[0]);
    assign m1_waitrequest   = ~reset_n | (req1 & ~grant[1]);
    assign m0_readdatavalid = reset_n & rd_pend[0];
    assign m1_readdatavalid = reset_n & rd_pend[1];
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

    assign mem_address    = grant[1] ? m1_address    : m0_address;
    assign mem_byteenable = grant[1] ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = grant[1] ? m1_writedata  : m0_writedata;
    assign mem_chipselect = |grant;
    assign mem_write      = (grant[0] & m0_write) | (grant[1] & m1_write);
    assign mem_clken      = reset_n;

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset_n || cnt_clear) begin
            m0_grant_count <= '0;
            m1_grant_count <= '0;
        end else begin
            m0_grant_count <= m0_grant_count + 32'(grant[0]);
            m1_grant_count <= m1_grant_count + 32'(grant[1]);
        end
    end
`endif

endmodule

// File: tb/tb_onchip_memory_rr_arbiter.sv
// Directed bench for onchip_memory_rr_arbiter with a behavioural byte-enabled RAM behind it.
// Exercises the grant counters too when ARB_PERF_CNT_EN is defined.
module tb_onchip_memory_rr_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
`ifdef ARB_PERF_CNT_EN
    logic        cnt_clear;
    logic [31:0] m0_grant_count, m1_grant_count;
`endif

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    onchip_memory_rr_arbiter #(.ADDR_W(10), .DATA_W(32), .BE_W(4), .MAX_HOLD(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
`ifdef ARB_PERF_CNT_EN
        , .cnt_clear(cnt_clear), .m0_grant_count(m0_grant_count), .m1_grant_count(m1_grant_count)
`endif
    );

    // 1024 x 32 single-port RAM, one-cycle read latency
    logic [31:0] ram [1024];
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    typedef struct {
        logic        rst_n;
        logic        r0, w0;
        logic [9:0]  a0;
        logic [3:0]  be0;
        logic [31:0] d0;
        logic        r1, w1;
        logic [9:0]  a1;
        logic [3:0]  be1;
        logic [31:0] d1;
        logic        wt0, wt1, cs, mw;
        logic [9:0]  maddr;
        logic        rdv0, rdv1, chk_rd;
        logic [31:0] rd;
    } vec_t;

    vec_t vecs [15];

    function automatic vec_t mk(logic rst_n,
                                logic r0, logic w0, logic [9:0] a0, logic [3:0] be0, logic [31:0] d0,
                                logic r1, logic w1, logic [9:0] a1, logic [3:0] be1, logic [31:0] d1,
                                logic wt0, logic wt1, logic cs, logic mw, logic [9:0] maddr,
                                logic rdv0, logic rdv1, logic chk_rd, logic [31:0] rd);
        vec_t v;
        v.rst_n = rst_n; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.be0 = be0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.be1 = be1; v.d1 = d1;
        v.wt0 = wt0; v.wt1 = wt1; v.cs = cs; v.mw = mw; v.maddr = maddr;
        v.rdv0 = rdv0; v.rdv1 = rdv1; v.chk_rd = chk_rd; v.rd = rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n,
                         input logic r0, input logic w0, input logic [9:0] a0,
                         input logic [3:0] be0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic [9:0] a1,
                         input logic [3:0] be1, input logic [31:0] d1);
        reset_n = rst_n;
        m0_read = r0; m0_write = w0; m0_address = a0; m0_byteenable = be0; m0_writedata = d0;
        m1_read = r1; m1_write = w1; m1_address = a1; m1_byteenable = be1; m1_writedata = d1;
    endtask

    task automatic step_idle(input logic rst_n);
        @(posedge clk); #1;
        drive(rst_n, 0, 0, 10'h0, 4'h0, 32'h0, 0, 0, 10'h0, 4'h0, 32'h0);
    endtask

    initial begin
        logic [1:0] g_exp [12];

`ifdef ARB_PERF_CNT_EN
        cnt_clear = 1'b0;
`endif
        drive(0, 0, 0, 10'h0, 4'h0, 32'h0, 0, 0, 10'h0, 4'h0, 32'h0);

        //          rst r0 w0 a0      be0   d0             r1 w1 a1      be1   d1             wt0 wt1 cs mw maddr  rdv0 rdv1 chk rd
        vecs[0]  = mk(0, 0, 0, 10'h000, 4'h0, 32'h0,         0, 0, 10'h000, 4'h0, 32'h0,         1, 1, 0, 0, 10'h000, 0, 0, 0, 32'h0);
        vecs[1]  = mk(0, 1, 0, 10'h005, 4'hF, 32'h0,         0, 0, 10'h000, 4'h0, 32'h0,         1, 1, 0, 0, 10'h000, 0, 0, 0, 32'h0);
        vecs[2]  = mk(1, 0, 1, 10'h005, 4'hF, 32'hDEADBEEF,  0, 0, 10'h000, 4'h0, 32'h0,         0, 0, 1, 1, 10'h005, 0, 0, 0, 32'h0);
        vecs[3]  = mk(1, 1, 0, 10'h005, 4'hF, 32'h0,         0, 0, 10'h000, 4'h0, 32'h0,         0, 0, 1, 0, 10'h005, 0, 0, 0, 32'h0);
        vecs[4]  = mk(1, 0, 0, 10'h000, 4'h0, 32'h0,         0, 0, 10'h000, 4'h0, 32'h0,         0, 0, 0, 0, 10'h000, 1, 0, 1, 32'hDEADBEEF);
        vecs[5]  = mk(1, 0, 0, 10'h000, 4'h0, 32'h0,         0, 1, 10'h3FF, 4'hF, 32'hAAAAAAAA,  0, 0, 1, 1, 10'h3FF, 0, 0, 0, 32'h0);
        vecs[6]  = mk(1, 0, 0, 10'h000, 4'h0, 32'h0,         0, 1, 10'h3FF, 4'h5, 32'h11223344,  0, 0, 1, 1, 10'h3FF, 0, 0, 0, 32'h0);
        vecs[7]  = mk(1, 0, 0, 10'h000, 4'h0, 32'h0,         1, 0, 10'h3FF, 4'hF, 32'h0,         0, 0, 1, 0, 10'h3FF, 0, 0, 0, 32'h0);
        vecs[8]  = mk(1, 0, 0, 10'h000, 4'h0, 32'h0,         0, 0, 10'h000, 4'h0, 32'h0,         0, 0, 0, 0, 10'h000, 0, 1, 1, 32'hAA22AA44);
        vecs[9]  = mk(1, 1, 1, 10'h010, 4'hF, 32'h0000CAFE,  0, 0, 10'h000, 4'h0, 32'h0,         0, 0, 1, 1, 10'h010, 0, 0, 0, 32'h0);
        vecs[10] = mk(1, 0, 0, 10'h000, 4'h0, 32'h0,         0, 0, 10'h000, 4'h0, 32'h0,         0, 0, 0, 0, 10'h000, 0, 0, 0, 32'h0);
        vecs[11] = mk(1, 1, 0, 10'h010, 4'hF, 32'h0,         0, 0, 10'h000, 4'h0, 32'h0,         0, 0, 1, 0, 10'h010, 0, 0, 0, 32'h0);
        vecs[12] = mk(1, 0, 0, 10'h000, 4'h0, 32'h0,         0, 0, 10'h000, 4'h0, 32'h0,         0, 0, 0, 0, 10'h000, 1, 0, 1, 32'h0000CAFE);
        // Contested writes from IDLE after m0 was last served: m1 wins
        vecs[13] = mk(1, 0, 1, 10'h020, 4'hF, 32'h1,         0, 1, 10'h021, 4'hF, 32'h2,         1, 0, 1, 1, 10'h021, 0, 0, 0, 32'h0);
        vecs[14] = mk(1, 0, 0, 10'h000, 4'h0, 32'h0,         0, 0, 10'h000, 4'h0, 32'h0,         0, 0, 0, 0, 10'h000, 0, 0, 0, 32'h0);

        for (int unsigned i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].rst_n, vecs[i].r0, vecs[i].w0, vecs[i].a0, vecs[i].be0, vecs[i].d0,
                  vecs[i].r1, vecs[i].w1, vecs[i].a1, vecs[i].be1, vecs[i].d1);
            @(negedge clk);
            check($sformatf("v%0d wait0", i), 32'(m0_waitrequest), 32'(vecs[i].wt0));
            check($sformatf("v%0d wait1", i), 32'(m1_waitrequest), 32'(vecs[i].wt1));
            check($sformatf("v%0d cs", i), 32'(mem_chipselect), 32'(vecs[i].cs));
            check($sformatf("v%0d mem_write", i), 32'(mem_write), 32'(vecs[i].mw));
            check($sformatf("v%0d clken", i), 32'(mem_clken), 32'(vecs[i].rst_n));
            check($sformatf("v%0d rdv0", i), 32'(m0_readdatavalid), 32'(vecs[i].rdv0));
            check($sformatf("v%0d rdv1", i), 32'(m1_readdatavalid), 32'(vecs[i].rdv1));
            if (vecs[i].cs)
                check($sformatf("v%0d mem_addr", i), 32'(mem_address), 32'(vecs[i].maddr));
            if (vecs[i].chk_rd)
                check($sformatf("v%0d rdata", i),
                      vecs[i].rdv1 ? m1_readdata : m0_readdata, vecs[i].rd);
        end

        // Round robin from reset with both masters reading continuously
        for (int unsigned i = 0; i < 12; i++) g_exp[i] = (i < 4 || i >= 8) ? 2'd1 : 2'd0;
        step_idle(0);
        for (int unsigned i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            drive(1, 1, 0, 10'h100, 4'hF, 32'h0, 1, 0, 10'h200, 4'hF, 32'h0);
            @(negedge clk);
            check($sformatf("rr%0d wait0", i), 32'(m0_waitrequest), 32'(g_exp[i] != 2'd0));
            check($sformatf("rr%0d wait1", i), 32'(m1_waitrequest), 32'(g_exp[i] != 2'd1));
            check($sformatf("rr%0d mem_addr", i), 32'(mem_address),
                  (g_exp[i] == 2'd1) ? 32'h200 : 32'h100);
            check($sformatf("rr%0d rdv0", i), 32'(m0_readdatavalid),
                  32'(i > 0 && g_exp[(i > 0) ? i - 1 : 0] == 2'd0));
            check($sformatf("rr%0d rdv1", i), 32'(m1_readdatavalid),
                  32'(i > 0 && g_exp[(i > 0) ? i - 1 : 0] == 2'd1));
        end

        // Reset lands the cycle after an accepted m0 read
        step_idle(1);
        @(posedge clk); #1;
        drive(1, 1, 0, 10'h005, 4'hF, 32'h0, 0, 0, 10'h000, 4'h0, 32'h0);
        @(negedge clk);
        check("rst_mid accept", 32'(m0_waitrequest), 32'h0);
        @(posedge clk); #1;
        drive(0, 0, 0, 10'h000, 4'h0, 32'h0, 1, 0, 10'h3FF, 4'hF, 32'h0);
        @(negedge clk);
        check("rst_mid rdv0", 32'(m0_readdatavalid), 32'h0);
        check("rst_mid cs", 32'(mem_chipselect), 32'h0);
        check("rst_mid clken", 32'(mem_clken), 32'h0);
        check("rst_mid wait1", 32'(m1_waitrequest), 32'h1);
        check("rst_mid wait0", 32'(m0_waitrequest), 32'h1);
        @(posedge clk); #1;
        drive(1, 0, 0, 10'h000, 4'h0, 32'h0, 1, 0, 10'h3FF, 4'hF, 32'h0);
        @(negedge clk);
        check("post_rst wait1", 32'(m1_waitrequest), 32'h0);
        check("post_rst cs", 32'(mem_chipselect), 32'h1);
        check("post_rst addr", 32'(mem_address), 32'h3FF);
        check("post_rst rdv0", 32'(m0_readdatavalid), 32'h0);
        step_idle(1);
        @(negedge clk);
        check("post_rst rdv1", 32'(m1_readdatavalid), 32'h1);
        check("post_rst rdata", m1_readdata, 32'hAA22AA44);
        check("post_rst no rdv0", 32'(m0_readdatavalid), 32'h0);

`ifdef ARB_PERF_CNT_EN
        @(posedge clk); #1;
        cnt_clear = 1'b1;
        @(posedge clk); #1;
        cnt_clear = 1'b0;
        for (int unsigned i = 0; i < 7; i++) begin
            drive(1, 0, 1, 10'(10'h040 + i), 4'hF, 32'(i), 0, 0, 10'h000, 4'h0, 32'h0);
            @(posedge clk); #1;
        end
        for (int unsigned i = 0; i < 3; i++) begin
            drive(1, 0, 0, 10'h000, 4'h0, 32'h0, 0, 1, 10'(10'h050 + i), 4'hF, 32'(i));
            @(posedge clk); #1;
        end
        drive(1, 0, 0, 10'h000, 4'h0, 32'h0, 0, 0, 10'h000, 4'h0, 32'h0);
        @(negedge clk);
        check("cnt m0", m0_grant_count, 32'd7);
        check("cnt m1", m1_grant_count, 32'd3);
        @(posedge clk); #1;
        cnt_clear = 1'b1;
        drive(1, 0, 1, 10'h060, 4'hF, 32'h0, 0, 0, 10'h000, 4'h0, 32'h0);
        @(posedge clk); #1;
        cnt_clear = 1'b0;
        drive(1, 0, 0, 10'h000, 4'h0, 32'h0, 0, 0, 10'h000, 4'h0, 32'h0);
        @(negedge clk);
        check("cnt clear m0", m0_grant_count, 32'd0);
        check("cnt clear m1", m1_grant_count, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
